// File: rtl/rst_seq_pkg.sv
// Shared definitions for the staged reset sequencer: bus encoding, register
// addresses, CAUSE bit positions and FSM state encodings.
package rst_seq_pkg;

  localparam int BUS_WIDTH     = 16;
  localparam int BUS_ACC_WIDTH = 2;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;

  localparam logic [1:0] RST_SEQ_CTRL  = 2'd0;
  localparam logic [1:0] RST_SEQ_HOLD  = 2'd1;
  localparam logic [1:0] RST_SEQ_GAP   = 2'd2;
  localparam logic [1:0] RST_SEQ_CAUSE = 2'd3;

  localparam int CAUSE_EXT = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_SW  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter for hold/gap intervals; done flags the last cycle
// of an interval (count == 1) and the count never drops below 1.
module rst_seq_timer #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VALUE = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= RST_VALUE;
    end else if (load) begin
      cnt_reg <= value;
    end else if (tick && (cnt_reg > WIDTH'(1))) begin
      cnt_reg <= cnt_reg - WIDTH'(1);
    end
  end

  assign done = (cnt_reg == WIDTH'(1));

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: merges external, watchdog and software triggers,
// holds all stage resets low, then releases stages one by one.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int STAGES       = 4,
  parameter int CNT_WIDTH    = 8,
  parameter int HOLD_DEFAULT = 16,
  parameter int GAP_DEFAULT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wdt_req,
  output logic [STAGES-1:0]        rst_ob,
  output logic                     busy,
  input  logic [1:0]               addr,
  input  logic                     w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] acc,
  output logic [BUS_WIDTH-1:0]     rdata,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic                     req,
  output logic                     resp,
  output logic                     fault
);

  localparam int STAGE_W = $clog2(STAGES + 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_RST = CNT_WIDTH'(HOLD_DEFAULT);
  localparam logic [CNT_WIDTH-1:0] GAP_RST  = CNT_WIDTH'(GAP_DEFAULT);
  localparam logic [CNT_WIDTH-1:0] HOLD_RST_EFF = (HOLD_DEFAULT == 0) ? CNT_WIDTH'(1) : HOLD_RST;
  localparam logic [BUS_WIDTH-1:0] CNT_MAX = BUS_WIDTH'((2 ** CNT_WIDTH) - 1);

  // A programmed zero still means one cycle.
  function automatic logic [CNT_WIDTH-1:0] at_least_one(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? CNT_WIDTH'(1) : v;
  endfunction

  logic [CNT_WIDTH-1:0] hold_reg;
  logic [CNT_WIDTH-1:0] gap_reg;
  logic [2:0]           cause_reg;
  logic                 resp_reg;
  logic [BUS_WIDTH-1:0] rdata_reg;

  logic invalid;
  logic valid;
  logic sw_trig;
  logic trig;

  always_comb begin
    invalid = 1'b0;
    if (acc != BUS_ACC_1B) begin
      invalid = 1'b1;
    end else begin
      case (addr)
        RST_SEQ_CTRL:             invalid = !w_rb || (wdata != BUS_WIDTH'(1));
        RST_SEQ_HOLD, RST_SEQ_GAP: invalid = w_rb && (wdata > CNT_MAX);
        default:                  invalid = w_rb;
      endcase
    end
  end

  assign fault   = req & invalid;
  assign valid   = req & ~invalid;
  assign sw_trig = valid & w_rb & (addr == RST_SEQ_CTRL);
  assign trig    = sw_trig | wdt_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg  <= HOLD_RST;
      gap_reg   <= GAP_RST;
      cause_reg <= 3'(1 << CAUSE_EXT);
      resp_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      resp_reg  <= valid;
      rdata_reg <= '0;
      if (valid && !w_rb) begin
        case (addr)
          RST_SEQ_HOLD:  rdata_reg <= BUS_WIDTH'(hold_reg);
          RST_SEQ_GAP:   rdata_reg <= BUS_WIDTH'(gap_reg);
          RST_SEQ_CAUSE: rdata_reg <= BUS_WIDTH'(cause_reg);
          default:       rdata_reg <= '0;
        endcase
      end
      if (valid && w_rb && (addr == RST_SEQ_HOLD)) hold_reg <= wdata[CNT_WIDTH-1:0];
      if (valid && w_rb && (addr == RST_SEQ_GAP))  gap_reg  <= wdata[CNT_WIDTH-1:0];
      if (trig) begin
        cause_reg            <= '0;
        cause_reg[CAUSE_SW]  <= sw_trig;
        cause_reg[CAUSE_WDT] <= wdt_req;
      end
    end
  end

  assign resp  = resp_reg;
  assign rdata = rdata_reg;

  seq_state_t           state_reg;
  logic [STAGE_W-1:0]   stage_reg;
  logic [STAGES-1:0]    rst_ob_reg;
  logic                 busy_reg;
  logic                 done;
  logic                 last_stage;
  logic                 tick;
  logic                 load;
  logic [CNT_WIDTH-1:0] load_value;

  assign last_stage = (stage_reg == STAGE_W'(STAGES - 1));
  assign tick       = (state_reg != ST_IDLE);
  // Reload the gap after every release except the last; triggers reload the hold.
  assign load       = trig | (tick & done & ~last_stage);
  assign load_value = trig ? at_least_one(hold_reg) : at_least_one(gap_reg);

  rst_seq_timer #(
    .WIDTH     (CNT_WIDTH),
    .RST_VALUE (HOLD_RST_EFF)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (load_value),
    .tick  (tick),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (rst || trig) begin
      state_reg  <= ST_ASSERT;
      stage_reg  <= '0;
      rst_ob_reg <= '0;
      busy_reg   <= 1'b1;
    end else begin
      case (state_reg)
        ST_ASSERT, ST_RELEASE: begin
          if (done) begin
            rst_ob_reg <= rst_ob_reg | (STAGES'(1) << stage_reg);
            stage_reg  <= stage_reg + STAGE_W'(1);
            if (last_stage) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= ST_RELEASE;
            end
          end
        end
        default: begin
          rst_ob_reg <= '1;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign rst_ob = rst_ob_reg;
  assign busy   = busy_reg;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Staged reset sequencer for the MCU reset domain.
- Merges reset triggers from external reset, watchdog and software into one sequence:
  - assert all module resets for a programmable hold time;
  - release stages 0..STAGES-1 in order, a programmable gap apart.
- Bus-configurable through a small register file that uses the standard MCU peripheral bus handshake.
- Its outputs feed the low-active per-module reset inputs.

Parameters:
- STAGES, 4: number of reset stages. Each stage is one rst_ob bit. Legal range 1..8.
- CNT_WIDTH, 8: width of the hold/gap counters and registers.
- HOLD_DEFAULT, 16: value loaded into HOLD on reset.
- GAP_DEFAULT, 4: value loaded into GAP on reset.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wdt_req  in  1  watchdog reset request; one-cycle pulse or level.
- rst_ob  out  STAGES  low-active staged resets; bit k = stage k.
- busy  out  1  high while a sequence is in progress.
- addr  in  2  register address.
- w_rb  in  1  1 = write, 0 = read.
- acc  in  `BUS_ACC_WIDTH  access size; only `BUS_ACC_1B is legal.
- rdata  out  `BUS_WIDTH  read data, valid with resp.
- wdata  in  `BUS_WIDTH  write data.
- req  in  1  bus request.
- resp  out  1  registered response, one cycle after a valid req.
- fault  out  1  combinational, = req & invalid.

Behaviour:
- Register map (all 1-byte):
  - 0 CTRL, W: wdata==1 triggers a software sequence.
  - 1 HOLD, RW: hold cycles.
  - 2 GAP, RW: inter-stage cycles.
  - 3 CAUSE, R: {sw,wdt,ext} in bits [2:0], zero-extended.
- Invalid access (fault=1, no resp, no side effect):
  - acc != `BUS_ACC_1B;
  - read of CTRL;
  - write of CAUSE;
  - write to CTRL with wdata!=1;
  - write to HOLD/GAP with wdata > 2^CNT_WIDTH-1.
- Bus response:
  - resp_r <= req & ~invalid.
  - rdata is registered with resp. It is 0 when no valid read is in flight.
- Effective counts: HOLD_eff = max(HOLD,1); GAP_eff = max(GAP,1).
- FSM states: IDLE, ASSERT, RELEASE. State is held in cnt (CNT_WIDTH) plus stage index (clog2(STAGES+1) bits).
- Reset (rst=1), every cycle:
  - state=ASSERT, cnt=HOLD_DEFAULT, stage=0;
  - rst_ob all 0, busy=1;
  - HOLD=HOLD_DEFAULT, GAP=GAP_DEFAULT, CAUSE=3'b001;
  - resp=0, rdata=0.
- Triggers:
  - wdt_req=1, or a valid CTRL write (sw_trig), from any state:
    - next state=ASSERT, cnt=HOLD_eff, stage=0, rst_ob all 0;
    - CAUSE <= {sw_trig, wdt_req, 0}.
  - Triggers in the same cycle are ORed into CAUSE.
  - rst has priority over both.
  - A trigger during ASSERT restarts the hold count.
  - A trigger during RELEASE re-asserts the already-released stages.
- ASSERT, per edge:
  - cnt>1: cnt decrements.
  - cnt==1: rst_ob[0] <= 1, stage=1. Then:
    - STAGES==1: go to IDLE;
    - otherwise: go to RELEASE with cnt=GAP_eff.
- RELEASE, per edge:
  - cnt>1: cnt decrements.
  - cnt==1: rst_ob[stage] <= 1, stage increments.
    - If stage was STAGES-1: go to IDLE.
    - Otherwise: cnt=GAP_eff.
- IDLE: rst_ob all 1, busy=0.
- busy is high in ASSERT and RELEASE. It falls on the same edge that releases the last stage.
- Timing: with edge 0 = first edge where rst=0 and no trigger:
  - rst_ob[k] rises after edge HOLD_eff-1 + k*GAP_eff, i.e. visible in the cycle after that edge;
  - a trigger sampled at edge T drives rst_ob to 0 from edge T.
- HOLD/GAP writes during a sequence are accepted. They take effect at the next counter load; a running count is unaffected.
- Released stages never toggle except on rst or a trigger. There is no glitching between stages.

Decomposition:
- Shared package/header `rst_seq.vh`:
  - register addresses RST_SEQ_CTRL/HOLD/GAP/CAUSE;
  - CAUSE bit positions;
  - FSM state encodings (IDLE=0, ASSERT=1, RELEASE=2).
- Bus decode/fault plus the register file stays inline.
- One natural sub-module: `rst_seq_timer`. It is the loadable down-counter: load, value, tick → done at cnt==1.

Test Plan:
- Power-on: rst=1 for 5 cycles, then 0; HOLD=16, GAP=4, STAGES=4.
  - Expect rst_ob 0000 through edge 14.
  - Bits rise in order, 0→1→2→3, at edges 15/19/23/27.
  - busy falls at edge 27; CAUSE reads 0x01.
- Software trigger: from IDLE, write HOLD=3, GAP=0, then CTRL=1.
  - Expect fault=0 and resp one cycle after each write.
  - rst_ob=0000 for 3 cycles, then stages release on consecutive cycles.
  - CAUSE=0x04.
- Watchdog mid-release: pulse wdt_req after stage 1 is released.
  - Expect rst_ob returns to 0000 that edge.
  - Full sequence restarts with the hold count.
  - CAUSE=0x02.
- Simultaneous triggers: wdt_req=1 in the same cycle as a valid CTRL write → CAUSE=0x06, one sequence.
- Reset priority: assert rst together with wdt_req → CAUSE=0x01; HOLD/GAP return to defaults.
- Fault cases: each of the following gives fault=1, resp=0 and no register change:
  - 2-byte access;
  - read of addr 0;
  - write of addr 3;
  - CTRL write with wdata=2;
  - HOLD write with wdata=256.
